// File: rtl/sha3_sponge_if.sv
// Bus bundle between the sponge controller and its surroundings: the
// absorb-side block stream, the Keccak-f[1600] core handshake and the
// squeeze-side output stream.
//
// Handshake semantics for both blk_* and out_* streams: a transfer happens
// on a rising clk edge where valid and ready are both 1. The source keeps
// valid and its payload stable until that edge. ready may depend
// combinationally on state but never on valid. valid=0 with ready=1 (or
// the reverse) moves nothing.
interface sha3_sponge_if #(
  parameter int RATE    = 1088,
  parameter int STATE_W = 1600,
  parameter int CNT_W   = 8
);
  // absorb stream
  logic                 blk_valid;
  logic                 blk_ready;
  logic [0:RATE-1]      blk_data;
  logic                 blk_last;
  logic [CNT_W-1:0]     sq_blocks;

  // permutation core handshake
  logic                 perm_start;
  logic [0:STATE_W-1]   perm_state_in;
  logic [0:STATE_W-1]   perm_state_out;
  logic [0:RATE-1]      perm_rate_out;
  logic                 perm_end;

  // squeeze stream
  logic                 out_valid;
  logic                 out_ready;
  logic [0:RATE-1]      out_data;
  logic                 out_last;

  // status
  logic                 busy;
  logic [2:0]           dbg_state;

  // controller side
  modport master (
    input  blk_valid, blk_data, blk_last, sq_blocks,
    input  perm_state_out, perm_rate_out, perm_end,
    input  out_ready,
    output blk_ready, perm_start, perm_state_in,
    output out_valid, out_data, out_last,
    output busy, dbg_state
  );

  // environment side (block source, core, consumer)
  modport slave (
    output blk_valid, blk_data, blk_last, sq_blocks,
    output perm_state_out, perm_rate_out, perm_end,
    output out_ready,
    input  blk_ready, perm_start, perm_state_in,
    input  out_valid, out_data, out_last,
    input  busy, dbg_state
  );
endinterface

// File: rtl/sha3_sponge_ctrl.sv
// Sponge sequencer for an external 24-round Keccak-f[1600] core.
// Absorbs pre-padded rate blocks into the chaining state, runs the core
// once per block via its start/end handshake, then squeezes a runtime
// selected number of rate blocks. Padding is the upstream's job.
module sha3_sponge_ctrl #(
  parameter int RATE    = 1088,
  parameter int STATE_W = 1600,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  sha3_sponge_if.master bus
);

  localparam int CAP_W = STATE_W - RATE;
  localparam int LANES = STATE_W / 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ABS_WAIT = 3'd1,
    RUN      = 3'd2,
    CLR      = 3'd3,
    SQZ      = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // first block of a message: chaining state starts from all-zero
  logic               first;
  // the block currently being permuted was flagged blk_last
  logic               last_f;
  // 0: current permutation absorbs, 1: it produces another squeeze block
  logic               mode_sq;
  logic               start_r;
  logic [CNT_W-1:0]   sq_lat;
  logic [CNT_W-1:0]   sq_cnt;
  logic [0:STATE_W-1] s_in;

  logic               rdy;
  logic               accept;
  logic               run_done;
  logic               sq_more;
  logic               sq_done;
  logic               is_last;
  logic [0:STATE_W-1] chain;
  logic [0:STATE_W-1] absorb_val;

  // The core returns S_out with each 64-bit lane as a plain word; S_in wants
  // the lanes as little-endian byte strings, so every lane is byte-reversed.
  function automatic logic [0:STATE_W-1] bswap_lanes(input logic [0:STATE_W-1] s);
    logic [0:STATE_W-1] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < 8; b++) begin
        r[l*64 + b*8 +: 8] = s[l*64 + (7-b)*8 +: 8];
      end
    end
    return r;
  endfunction

  assign chain      = bswap_lanes(bus.perm_state_out);
  assign absorb_val = (first ? {STATE_W{1'b0}} : chain) ^ {bus.blk_data, {CAP_W{1'b0}}};

  assign rdy     = (state == IDLE) || (state == ABS_WAIT);
  assign is_last = (state == SQZ) && (sq_cnt == sq_lat - CNT_W'(1));

  assign bus.blk_ready     = rdy;
  assign bus.perm_start    = start_r;
  assign bus.perm_state_in = s_in;
  assign bus.out_valid     = (state == SQZ);
  assign bus.out_data      = bus.perm_rate_out;
  assign bus.out_last      = is_last;
  assign bus.busy          = (state != IDLE);
  assign bus.dbg_state     = state;

  // Next-state decode plus one-cycle action strobes for the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_done  = 1'b0;
    sq_more   = 1'b0;
    sq_done   = 1'b0;
    case (state)
      IDLE, ABS_WAIT: begin
        if (bus.blk_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.perm_end) begin
          run_done  = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: begin
        // start is only re-raised once the core has dropped end
        if (!bus.perm_end) begin
          if (mode_sq || last_f) state_nxt = SQZ;
          else                   state_nxt = ABS_WAIT;
        end
      end
      SQZ: begin
        if (bus.out_ready) begin
          if (is_last) begin
            sq_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            sq_more   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and sponge datapath, updated on the strobes above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      first   <= 1'b1;
      last_f  <= 1'b0;
      mode_sq <= 1'b0;
      start_r <= 1'b0;
      sq_lat  <= '0;
      sq_cnt  <= '0;
      s_in    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sq_lat  <= (bus.sq_blocks == '0) ? CNT_W'(1) : bus.sq_blocks;
        sq_cnt  <= '0;
        s_in    <= absorb_val;
        last_f  <= bus.blk_last;
        mode_sq <= 1'b0;
        start_r <= 1'b1;
        first   <= 1'b0;
      end
      if (run_done) begin
        start_r <= 1'b0;
      end
      if (sq_more) begin
        sq_cnt  <= sq_cnt + CNT_W'(1);
        s_in    <= chain;
        mode_sq <= 1'b1;
        start_r <= 1'b1;
      end
      if (sq_done) begin
        first <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sha3_sponge_ctrl.md
Name: sha3_sponge_ctrl

Overview:
Sponge sequencer for the 24-round Keccak-f[1600] permutation core (sha3_f_func) in the Picnic hash path. It accepts pre-padded 1088-bit rate blocks over a valid/ready handshake and XORs each block into the chaining state. It drives the core's start/end handshake once per block, then squeezes a runtime-selected number of 1088-bit output blocks (SHA3-256 / SHAKE256 rate). Padding is done upstream; this block only absorbs, permutes and squeezes.

Parameters:
RATE, 1088, rate width in bits (byte-string order, bit 0 = MSB of first byte)
STATE_W, 1600, permutation state width
CNT_W, 8, width of squeeze block counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
blk_valid  in  1  rate block available
blk_ready  out  1  controller can accept block
blk_data  in  [0:RATE-1]  padded rate block, byte-string order
blk_last  in  1  final absorb block of message
sq_blocks  in  [CNT_W-1:0]  output blocks to squeeze; sampled with first block; 0 treated as 1
perm_start  out  1  to core sha3_start
perm_state_in  out  [0:STATE_W-1]  to core S_in (byte-string order)
perm_state_out  in  [0:STATE_W-1]  from core S_out (lane order)
perm_rate_out  in  [0:RATE-1]  from core r_out (byte-string order)
perm_end  in  1  from core sha3_end
out_valid  out  1  squeeze block valid
out_ready  in  1  consumer accepts squeeze block
out_data  out  [0:RATE-1]  squeeze block, byte-string order
out_last  out  1  final squeeze block of message
busy  out  1  message in progress (not IDLE)

Behaviour:
- All state registered on posedge clk. Reset (sync, high) overrides everything: state=IDLE, first=1, perm_start=0, out_valid=0, out_last=0, busy=0, counters=0, perm_state_in=0. Reset mid-permutation drops perm_start immediately; the core is reset separately by the system.
- States: IDLE, ABS_WAIT, RUN, CLR, SQZ.
- blk_ready=1 only in IDLE or ABS_WAIT (combinational from state). Accept = blk_valid & blk_ready.
- Accept in IDLE: latch sq_blocks (0 -> 1), clear sq_cnt, perm_state_in <= {blk_data, 512'b0}, last_f <= blk_last, mode=ABSORB, perm_start <= 1, go RUN.
- Accept in ABS_WAIT: perm_state_in <= bswap_lanes(perm_state_out) ^ {blk_data, 512'b0}, with the same updates as above. bswap_lanes byte-reverses each of the 25 64-bit lanes, converting the core's lane-order output back to the byte-string order the core expects on S_in.
- RUN: hold perm_start=1 and perm_state_in stable. On perm_end=1: perm_start <= 0, go CLR.
- CLR: wait until perm_end=0 (the core clears end one cycle after start drops). Then:
  - mode=ABSORB & !last_f: go ABS_WAIT.
  - mode=ABSORB & last_f: go SQZ.
  - mode=SQUEEZE: go SQZ.
- SQZ: out_valid=1, out_data=perm_rate_out, out_last=(sq_cnt==sq_lat-1). On out_ready:
  - If last: go IDLE, first=1, out_valid drops next cycle.
  - Else: sq_cnt++, perm_state_in <= bswap_lanes(perm_state_out), mode=SQUEEZE, perm_start <= 1, go RUN.
- out_data is stable while out_valid=1 and !out_ready. out_ready with out_valid=0 is ignored. blk_valid outside IDLE/ABS_WAIT is ignored (not consumed).
- busy=1 in every state except IDLE.
- Latency: accept -> perm_start high the next cycle. Core completion is governed by perm_end, nominally 26 cycles after start. CLR lasts 1 cycle with a conforming core. Per-block throughput is about 29 cycles.
- perm_start is never re-raised while perm_end=1, so no spurious runs occur.

Test Plan:
- SHA3-256(""): one block, byte0=0x06, byte135=0x80, rest 0, blk_last=1, sq_blocks=1 -> out_data[0:255]=a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a, out_last=1, then busy=0.
- Two-block SHA3-256 of 200 bytes of 0xA3 (padded upstream) -> out_data[0:255]=79f38adec5c20307a98ef76e8324afbfd46cfd81b22e3973c65fa1bd9de31787. blk_ready low between blocks until CLR completes.
- SHAKE256(""), sq_blocks=3 -> three out_valid beats, out_last only on the third. First 32 bytes = 46b9dd2b0ba88d13233b3feb743eeb243fcd52ea62b81b82b50c27646ed5762f. Three perm_start pulses after absorb.
- Backpressure: hold out_ready=0 for 50 cycles in SQZ -> out_data/out_valid stable, no perm_start. sq_blocks=0 -> exactly one beat with out_last=1.
- Reset asserted mid-RUN (cycle 10 of permutation) -> next cycle perm_start=0, busy=0, blk_ready=1. A fresh SHA3-256("") afterwards produces the correct digest.
- blk_valid held high during RUN/SQZ -> no accept (blk_ready=0), block consumed only in ABS_WAIT.
